cpu_clock_sequencer: RTL and testbench
======================================

# cpu_clock_sequencer

Run/stop/single-step controller for the CPU's divided clock enable. It generates a programmable-period tick strobe and advances a multi-phase instruction counter (fetch/decode/execute/writeback) on each tick. Starts and stops are aligned to instruction boundaries, and divisor changes are deferred to the next boundary. It sits between the debug/board controls and the CPU core, which gates its state updates with `tick` and `phase`.

## Interface
- `DIV_W`, default 16: width of divisor, counter and `div_value`.
- `DEFAULT_DIV`, default 1: divisor loaded at reset; tick period is `div_active+1` clocks.
- `PHASES`, default 4: ticks per instruction; must be at least 2.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `clr`, input, 1: reset; synchronous, active-low.
- `run`, input, 1: level; free-run request.
- `step`, input, 1: single-cycle request for one instruction.
- `div_load`, input, 1: single-cycle strobe; load `div_value`.
- `div_value`, input, `DIV_W`: new divisor.
- `tick`, output, 1: one-clock enable strobe to the CPU.
- `phase`, output, `$clog2(PHASES)`: current instruction phase, 0..`PHASES-1`.
- `state`, output, 2: 0=IDLE, 1=RUN, 2=STEP.
- `div_active`, output, `DIV_W`: divisor in use.
- `div_pending`, output, 1: a deferred divisor load is waiting.
- `step_done`, output, 1: one-cycle pulse when a step completes.

## Operation
- Reset (`clr`=0 at an edge) gives:
  - `state`=IDLE, `counter`=0, `phase`=0
  - `div_active`=`DEFAULT_DIV`, pending register=0, `div_pending`=0
  - `step_done`=0, `tick`=0
- Reset mid-instruction abandons it; there is no completion pulse.
- `tick` = (`state`≠IDLE) && (`counter`==`div_active`). It is decoded only from registers.
- Counter:
  - In RUN/STEP it increments each edge.
  - On an edge with `tick`=1 it wraps to 0.
  - It never exceeds `div_active`. It holds at 0 in IDLE.
- Phase:
  - On each edge with `tick`=1, `phase` advances by 1, wrapping `PHASES-1`→0.
  - It is unchanged otherwise.
- Boundary: an edge with `tick`=1 and `phase`==`PHASES-1`.
- IDLE transitions:
  - `run`=1 → RUN.
  - else `step`=1 → STEP.
  - `run` wins if both are high.
  - The counter is 0 on entry.
- RUN transitions:
  - At a boundary: `run`=0 → IDLE, else stay in RUN.
  - Dropping `run` mid-instruction finishes the instruction.
  - `step` is ignored.
- STEP transitions:
  - At a boundary: `run`=1 → RUN, else IDLE.
  - `step_done`=1 for exactly the one cycle after that boundary edge.
  - `step` is ignored while in STEP.
- Divisor load:
  - `div_load` in IDLE, or on a boundary edge: `div_active`←`div_value` at that edge.
  - `div_load` in RUN/STEP off-boundary: the value goes to the pending register and `div_pending`=1. A later load overwrites the pending value.
  - At the next boundary, `div_active`←pending value and `div_pending`←0.
  - A direct load on a boundary edge beats an older pending value.
- On exit to IDLE, `phase` is always 0. A pending load is applied at that same boundary.

## Timing
- Cycle 0 is the first cycle with `state`=RUN/STEP.
- `tick` is high in cycles `div_active`, `2·div_active+1`, …; the period is `div_active+1`.
- With `div_active`=0, `tick` is high every cycle from cycle 0.
- One instruction takes `PHASES·(div_active+1)` cycles.
- The state change at a boundary is visible in the cycle after the boundary edge. `tick`=0 in that cycle if the new state is IDLE.
- STEP→RUN at a boundary: the counter restarts at 0, so there is no lost or doubled tick.
- `run` and `step` are sampled only in IDLE, or at boundaries in the case of `run`. There is no latency beyond one edge.

## Test plan
- Reset with `DEFAULT_DIV`=1, then `run`=1 → `tick` in cycles 1,3,5,7,9; `phase` 0→1→2→3→0; `div_pending`=0.
- `div_load`, `div_value`=0 in IDLE, then `run` → `tick` every cycle; `phase` increments every clock.
- `div_value`=2, one-cycle `step`, `PHASES`=4 → ticks in cycles 2,5,8,11; then IDLE, `step_done` high one cycle, `phase`=0, no further ticks.
- `div`=1, RUN, drop `run` when `phase`=1 → ticks continue through the `phase`=3 tick, then IDLE.
- `div`=1, RUN, `div_load` 5 at `phase`=1 → `div_pending`=1 and period stays 2 until the boundary; then `div_active`=5, period 6, `div_pending`=0.
- `clr` low during RUN at `phase`=2 → next cycle IDLE, `phase`=0, `tick`=0, `div_active`=`DEFAULT_DIV`, `step_done`=0.

Source files
------------

// File: rtl/cpu_clock_sequencer_if.sv
// Control/status bundle between the board/debug controls and the clock sequencer.
// The master drives run/step/divisor requests; the sequencer answers with tick, phase and status.
interface cpu_clock_sequencer_if #(
   parameter int DIV_W   = 16,
   parameter int PHASE_W = 2
);
   logic               run;
   logic               step;
   logic               div_load;
   logic [DIV_W-1:0]   div_value;
   logic               tick;
   logic [PHASE_W-1:0] phase;
   logic [1:0]         state;
   logic [DIV_W-1:0]   div_active;
   logic               div_pending;
   logic               step_done;

   modport master (
      output run, step, div_load, div_value,
      input  tick, phase, state, div_active, div_pending, step_done
   );

   modport slave (
      input  run, step, div_load, div_value,
      output tick, phase, state, div_active, div_pending, step_done
   );
endinterface

// File: rtl/cpu_clock_sequencer.sv
// Run/stop/single-step sequencer producing the CPU's divided tick strobe and instruction phase.
// Starts, stops and divisor changes all take effect on instruction boundaries.
module cpu_clock_sequencer #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 1,
   parameter int PHASES      = 4
) (
   input logic                   clk,
   input logic                   clr,
   cpu_clock_sequencer_if.slave  bus
);
   localparam int PHASE_W = $clog2(PHASES);
   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);
   localparam logic [DIV_W-1:0]   DIV_RESET  = DIV_W'(DEFAULT_DIV);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   state_t             state_q;
   logic [DIV_W-1:0]   counter_q;
   logic [DIV_W-1:0]   div_active_q;
   logic [DIV_W-1:0]   div_pend_val_q;
   logic               div_pend_q;
   logic [PHASE_W-1:0] phase_q;
   logic               step_done_q;

   logic tick;
   logic boundary;

   // Tick is decoded purely from registers so the CPU sees a glitch-free, edge-aligned enable.
   assign tick     = (state_q != IDLE) && (counter_q == div_active_q);
   assign boundary = tick && (phase_q == LAST_PHASE);

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q        <= IDLE;
         counter_q      <= '0;
         phase_q        <= '0;
         div_active_q   <= DIV_RESET;
         div_pend_val_q <= '0;
         div_pend_q     <= 1'b0;
         step_done_q    <= 1'b0;
      end else begin
         step_done_q <= 1'b0;
         if (state_q == IDLE) begin
            counter_q <= '0;
            phase_q   <= '0;
            if (bus.div_load) div_active_q <= bus.div_value;
            if (bus.run)       state_q <= RUN;
            else if (bus.step) state_q <= STEP;
         end else begin
            if (tick) begin
               counter_q <= '0;
               phase_q   <= (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
            end else begin
               counter_q <= counter_q + 1'b1;
            end

            if (boundary) begin
               // A load arriving on the boundary itself supersedes any older deferred value.
               if (bus.div_load)    div_active_q <= bus.div_value;
               else if (div_pend_q) div_active_q <= div_pend_val_q;
               div_pend_q <= 1'b0;

               if (state_q == STEP) begin
                  step_done_q <= 1'b1;
                  state_q     <= bus.run ? RUN : IDLE;
               end else begin
                  state_q     <= bus.run ? RUN : IDLE;
               end
            end else if (bus.div_load) begin
               div_pend_val_q <= bus.div_value;
               div_pend_q     <= 1'b1;
            end
         end
      end
   end

   assign bus.tick        = tick;
   assign bus.phase       = phase_q;
   assign bus.state       = state_q;
   assign bus.div_active  = div_active_q;
   assign bus.div_pending = div_pend_q;
   assign bus.step_done   = step_done_q;
endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed bench for cpu_clock_sequencer: run, free-run at div 0, single step, mid-instruction stop,
// deferred divisor loads and reset mid-run, all against hand-computed tick/phase patterns.
module tb_cpu_clock_sequencer;
   localparam int DIV_W   = 16;
   localparam int PHASES  = 4;
   localparam int PHASE_W = 2;

   logic clk = 1'b0;
   logic clr;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] tmask;
   logic [31:0] pmask;

   always #5 clk = ~clk;

   cpu_clock_sequencer_if #(.DIV_W(DIV_W), .PHASE_W(PHASE_W)) bus ();

   cpu_clock_sequencer #(
      .DIV_W(DIV_W),
      .DEFAULT_DIV(1),
      .PHASES(PHASES)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   // Advance one clock and settle just after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_idle(input logic [DIV_W-1:0] v);
      bus.div_load  = 1'b1;
      bus.div_value = v;
      cyc();
      bus.div_load  = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr           = 1'b0;
      bus.run       = 1'b0;
      bus.step      = 1'b0;
      bus.div_load  = 1'b0;
      bus.div_value = '0;
      cyc();
      cyc();
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_phase", 32'(bus.phase), 32'd0);
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_div_active", 32'(bus.div_active), 32'd1);
      check("rst_div_pending", 32'(bus.div_pending), 32'd0);
      check("rst_step_done", 32'(bus.step_done), 32'd0);
      clr = 1'b1;
      cyc();

      // Free run at div 1: ticks in odd cycles, phase advances after each tick.
      bus.run = 1'b1;
      cyc();
      tmask = '0;
      pmask = '0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) cyc();
         tmask[c]       = bus.tick;
         pmask[2*c +: 2] = bus.phase;
      end
      check("run1_ticks", tmask, 32'h2AA);
      check("run1_phases", pmask, 32'hFA50);
      check("run1_pending", 32'(bus.div_pending), 32'd0);
      bus.run = 1'b0;
      for (int c = 10; c <= 16; c++) cyc();
      check("run1_stop_state", 32'(bus.state), 32'd0);
      check("run1_stop_phase", 32'(bus.phase), 32'd0);

      // Divisor 0: tick every cycle, phase increments every clock.
      load_idle(16'd0);
      check("div0_active", 32'(bus.div_active), 32'd0);
      bus.run = 1'b1;
      cyc();
      tmask = '0;
      pmask = '0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) cyc();
         tmask[c]        = bus.tick;
         pmask[2*c +: 2] = bus.phase;
      end
      check("div0_ticks", tmask, 32'hFF);
      check("div0_phases", pmask, 32'hE4E4);
      bus.run = 1'b0;
      cyc();
      check("div0_stop_state", 32'(bus.state), 32'd0);
      check("div0_stop_tick", 32'(bus.tick), 32'd0);

      // Single step at div 2: ticks in cycles 2,5,8,11, then IDLE with a step_done pulse.
      load_idle(16'd2);
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      check("step_state", 32'(bus.state), 32'd2);
      tmask = '0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) cyc();
         tmask[c] = bus.tick;
      end
      check("step_ticks", tmask, 32'h924);
      check("step_done_early", 32'(bus.step_done), 32'd0);
      cyc();
      check("step_end_state", 32'(bus.state), 32'd0);
      check("step_done_pulse", 32'(bus.step_done), 32'd1);
      check("step_end_phase", 32'(bus.phase), 32'd0);
      check("step_end_tick", 32'(bus.tick), 32'd0);
      tmask = '0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         tmask[c] = bus.tick;
      end
      check("step_done_cleared", 32'(bus.step_done), 32'd0);
      check("step_no_more_ticks", tmask, 32'h0);

      // Step converted to run at its boundary: counter restarts, no lost tick.
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      for (int c = 1; c < 12; c++) cyc();
      bus.run = 1'b1;
      cyc();
      check("step2run_state", 32'(bus.state), 32'd1);
      check("step2run_done", 32'(bus.step_done), 32'd1);
      bus.run = 1'b0;
      tmask = '0;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) cyc();
         tmask[c] = bus.tick;
         if (c == 1) check("step2run_done_clr", 32'(bus.step_done), 32'd0);
      end
      check("step2run_ticks", tmask, 32'h924);
      check("step2run_idle", 32'(bus.state), 32'd0);

      // Drop run at phase 1: instruction finishes through the phase-3 tick.
      load_idle(16'd1);
      bus.run = 1'b1;
      cyc();
      tmask = '0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) cyc();
         tmask[c] = bus.tick;
         if (c == 2) begin
            check("drop_phase1", 32'(bus.phase), 32'd1);
            bus.run = 1'b0;
         end
      end
      check("drop_ticks", tmask, 32'hAA);
      check("drop_state", 32'(bus.state), 32'd0);
      check("drop_phase", 32'(bus.phase), 32'd0);

      // Deferred load of 5 at phase 1: period 2 until the boundary, then period 6.
      bus.run = 1'b1;
      cyc();
      tmask = '0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) cyc();
         tmask[c] = bus.tick;
         if (c == 2) begin
            bus.div_load  = 1'b1;
            bus.div_value = 16'd5;
         end
         if (c == 3) begin
            bus.div_load = 1'b0;
            check("defer_pending", 32'(bus.div_pending), 32'd1);
            check("defer_active_old", 32'(bus.div_active), 32'd1);
         end
         if (c == 8) begin
            check("defer_active_new", 32'(bus.div_active), 32'd5);
            check("defer_pending_clr", 32'(bus.div_pending), 32'd0);
         end
      end
      check("defer_ticks", tmask, 32'h820AA);
      cyc();
      check("preclr_phase", 32'(bus.phase), 32'd2);

      // Reset mid-instruction at phase 2.
      clr     = 1'b0;
      bus.run = 1'b0;
      cyc();
      check("midclr_state", 32'(bus.state), 32'd0);
      check("midclr_phase", 32'(bus.phase), 32'd0);
      check("midclr_tick", 32'(bus.tick), 32'd0);
      check("midclr_div_active", 32'(bus.div_active), 32'd1);
      check("midclr_step_done", 32'(bus.step_done), 32'd0);
      clr = 1'b1;
      cyc();

      // Run wins over step; pending overwrite applied on the exit boundary.
      bus.run  = 1'b1;
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      check("run_wins", 32'(bus.state), 32'd1);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) cyc();
         if (c == 2 || c == 4) begin
            bus.div_load  = 1'b1;
            bus.div_value = (c == 2) ? 16'd7 : 16'd3;
         end else begin
            bus.div_load = 1'b0;
         end
         if (c == 5) check("overwrite_pending", 32'(bus.div_pending), 32'd1);
         if (c == 7) bus.run = 1'b0;
      end
      check("overwrite_state", 32'(bus.state), 32'd0);
      check("overwrite_active", 32'(bus.div_active), 32'd3);
      check("overwrite_pending_clr", 32'(bus.div_pending), 32'd0);
      check("overwrite_phase", 32'(bus.phase), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
